// File: rtl/bus_serial_tx.sv
// Memory-mapped 8N1 serial transmitter with an 8-deep TX FIFO.
// Responds on an async-strobe 16-bit bus with a combinational read path.
module bus_serial_tx #(
  parameter int          FIFO_AW     = 3,
  parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
  input  logic        clock,
  input  logic        notReset,
  input  logic [15:0] address,
  inout  wire  [15:0] data,
  input  logic        memNotRead,
  input  logic        memNotWrite,
  input  logic        notSelect,
  output logic        tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT =
    {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [15:0]        divisor_q, divisor_d;
  logic               overflow_q, overflow_d;
  logic               wprev_q;

  logic        wr_act, fire;
  logic        push_req, push, pop;
  logic        full, empty, busy;
  logic [15:0] status, rdata;
  logic        unused_addr;

  assign unused_addr = ^address[15:2];

  assign wr_act   = !notSelect && !memNotWrite;
  assign fire     = wr_act && !wprev_q;
  assign full     = count_q == FULL_CNT;
  assign empty    = count_q == '0;
  assign busy     = state_q != IDLE;
  assign push_req = fire && address[1:0] == 2'd0;
  assign push     = push_req && !full;
  assign pop      = state_q == IDLE && !empty;
  assign tx       = tx_q;

  assign status = {4'b0, 4'(count_q), 4'b0,
                   overflow_q, busy, full, empty};

  always_comb begin
    rdata = '0;
    case (address[1:0])
      2'd1:    rdata = status;
      2'd2:    rdata = divisor_q;
      default: rdata = '0;
    endcase
  end

  assign data = (!notSelect && !memNotRead) ? rdata : 16'bz;

  always_comb begin
    divisor_d  = divisor_q;
    overflow_d = overflow_q;
    count_d    = count_q;
    if (push_req && full)
      overflow_d = 1'b1;
    if (fire && address[1:0] == 2'd1 && data[3])
      overflow_d = 1'b0;
    if (fire && address[1:0] == 2'd2)
      divisor_d = data;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = START;
          shift_d = mem_q[rptr_q];
          cnt_d   = divisor_q;
          idx_d   = '0;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = divisor_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = divisor_q;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0)
          state_d = IDLE;
        else
          cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // tx is registered from the next state so it never glitches
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      divisor_q  <= DEFAULT_DIV;
      overflow_q <= 1'b0;
      wprev_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      count_q    <= count_d;
      divisor_q  <= divisor_d;
      overflow_q <= overflow_d;
      wprev_q    <= wr_act;
      if (push)
        wptr_q <= wptr_q + 1'b1;
      if (pop)
        rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem_q[wptr_q] <= data[7:0];
  end

endmodule
